// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic unit: op codes, FSM states and
// the width helpers that derive the binary datapath size from the digit count.
package bcd_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    ARITH  = 2'd2,
    DABBLE = 2'd3
  } state_e;

  function automatic longint pow10(input int digits);
    longint p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p;
  endfunction

  function automatic int calc_bin_w(input int digits);
    return $clog2(pow10(digits));
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: load a binary value, then BIN_W shift-and-add-3
// steps; done strobes high together with the final BCD value.
module bin_to_bcd_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [BIN_W-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                done
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    bin_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt_reg;
  logic                active_reg;
  logic                done_reg;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                         : bcd_reg[4*gi +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else if (load) begin
      bin_reg    <= bin;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
      done_reg   <= 1'b0;
    end else if (active_reg) begin
      {bcd_reg, bin_reg} <= {adj, bin_reg} << 1;
      cnt_reg    <= cnt_reg + 1'b1;
      done_reg   <= (cnt_reg == CNT_W'(BIN_W - 1));
      active_reg <= (cnt_reg != CNT_W'(BIN_W - 1));
    end else begin
      done_reg   <= 1'b0;
    end
  end

  assign bcd  = bcd_reg;
  assign done = done_reg;

endmodule

// File: rtl/bcd_alu_seq.sv
// BCD add/subtract unit: serial BCD-to-binary conversion, signed-magnitude
// arithmetic on operands or a running accumulator, sequential BCD result.
module bcd_alu_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [4*DIGITS-1:0] num1,
  input  logic [4*DIGITS-1:0] num2,
  output logic                busy,
  output logic                done,
  output logic                isValid,
  output logic [4*DIGITS-1:0] res,
  output logic                isNeg,
  output logic                overflow,
  output logic                error
);
  localparam int BIN_W = calc_bin_w(DIGITS);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W+1:0] LIMIT = (BIN_W+2)'(pow10(DIGITS));

  state_e              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [1:0]          op_reg;
  logic [4*DIGITS-1:0] a_reg, b_reg;
  logic [BIN_W-1:0]    bin_a_reg, bin_b_reg;
  logic                conv_err_reg;
  logic                acc_neg_reg;
  logic [BIN_W:0]      acc_mag_reg;
  logic                pend_neg_reg, pend_ovf_reg, pend_err_reg;
  logic [4*DIGITS-1:0] res_reg;
  logic                neg_reg, ovf_reg, err_reg, valid_reg;

  logic                accept, last_conv, last_dabble;
  logic [3:0]          dig_a, dig_b;
  logic [BIN_W+1:0]    mag_a, mag_b, sum;
  logic                neg_a, neg_b, sum_neg, ovf, wrapped_neg;
  logic [BIN_W:0]      wrapped;
  logic                dab_load, dab_done;
  logic [BIN_W-1:0]    dab_bin;
  logic [4*DIGITS-1:0] dab_bcd;

  assign accept      = (state_reg == IDLE) && start;
  assign last_conv   = (cnt_reg == CNT_W'(DIGITS - 1));
  assign last_dabble = (cnt_reg == CNT_W'(BIN_W - 1));
  assign dig_a       = a_reg[4*DIGITS-1 -: 4];
  assign dig_b       = b_reg[4*DIGITS-1 -: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (last_conv) state_next = ARITH;
      ARITH:   state_next = DABBLE;
      DABBLE:  if (last_dabble) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Signed-magnitude add; B's sign comes from the subtract bit of op.
  always_comb begin
    mag_a   = op_reg[1] ? {1'b0, acc_mag_reg} : {2'b00, bin_a_reg};
    neg_a   = op_reg[1] ? acc_neg_reg : 1'b0;
    mag_b   = {2'b00, bin_b_reg};
    neg_b   = op_reg[0];
    sum     = mag_a + mag_b;
    sum_neg = neg_a;
    if (neg_a != neg_b) begin
      if (mag_a >= mag_b) begin
        sum = mag_a - mag_b;
      end else begin
        sum     = mag_b - mag_a;
        sum_neg = neg_b;
      end
    end
    ovf         = (sum >= LIMIT);
    wrapped     = (BIN_W+1)'(ovf ? sum - LIMIT : sum);
    wrapped_neg = sum_neg && (wrapped != '0);
  end

  assign dab_load = (state_reg == ARITH);
  assign dab_bin  = conv_err_reg ? '0 : wrapped[BIN_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      bin_a_reg    <= '0;
      bin_b_reg    <= '0;
      conv_err_reg <= 1'b0;
      acc_neg_reg  <= 1'b0;
      acc_mag_reg  <= '0;
      pend_neg_reg <= 1'b0;
      pend_ovf_reg <= 1'b0;
      pend_err_reg <= 1'b0;
      res_reg      <= '0;
      neg_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      err_reg      <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          op_reg       <= op;
          a_reg        <= num1;
          b_reg        <= num2;
          bin_a_reg    <= '0;
          bin_b_reg    <= '0;
          conv_err_reg <= 1'b0;
          cnt_reg      <= '0;
        end
        CONV: begin
          bin_a_reg    <= BIN_W'(bin_a_reg * 10 + dig_a);
          bin_b_reg    <= BIN_W'(bin_b_reg * 10 + dig_b);
          a_reg        <= a_reg << 4;
          b_reg        <= b_reg << 4;
          conv_err_reg <= conv_err_reg | (dig_a > 4'd9) | (dig_b > 4'd9);
          cnt_reg      <= last_conv ? '0 : cnt_reg + 1'b1;
        end
        ARITH: begin
          pend_err_reg <= conv_err_reg;
          pend_neg_reg <= !conv_err_reg && wrapped_neg;
          pend_ovf_reg <= !conv_err_reg && ovf;
          if (!conv_err_reg) begin
            acc_neg_reg <= wrapped_neg;
            acc_mag_reg <= wrapped;
          end
          cnt_reg <= '0;
        end
        DABBLE:  cnt_reg <= cnt_reg + 1'b1;
        default: ;
      endcase

      if (dab_done) begin
        res_reg <= dab_bcd;
        neg_reg <= pend_neg_reg;
        ovf_reg <= pend_ovf_reg;
        err_reg <= pend_err_reg;
      end

      if (accept)        valid_reg <= 1'b0;
      else if (dab_done) valid_reg <= 1'b1;
    end
  end

  bin_to_bcd_seq #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) u_dabble (
    .clk  (clk),
    .rst_n(rst_n),
    .load (dab_load),
    .bin  (dab_bin),
    .bcd  (dab_bcd),
    .done (dab_done)
  );

  // Results are presented straight from the converter during the done cycle
  // and from the holding registers afterwards.
  assign busy     = (state_reg != IDLE);
  assign done     = dab_done;
  assign isValid  = valid_reg | dab_done;
  assign res      = dab_done ? dab_bcd      : res_reg;
  assign isNeg    = dab_done ? pend_neg_reg : neg_reg;
  assign overflow = dab_done ? pend_ovf_reg : ovf_reg;
  assign error    = dab_done ? pend_err_reg : err_reg;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Randomised and directed bench for bcd_alu_seq (DIGITS=4) against a plain
// integer model of the calculator, including accumulator, error and reset cases.
module tb_bcd_alu_seq;
  import bcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] num1 = '0;
  logic [15:0] num2 = '0;
  logic        busy, done, isValid, isNeg, overflow, error;
  logic [15:0] res;

  int tests = 0;
  int fails = 0;
  int acc = 0;
  logic [15:0] prev_res = '0;
  logic        prev_neg = 1'b0;
  logic        prev_ovf = 1'b0;
  logic        prev_err = 1'b0;

  bcd_alu_seq #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .num1(num1), .num2(num2),
    .busy(busy), .done(done), .isValid(isValid), .res(res), .isNeg(isNeg),
    .overflow(overflow), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd_val(input logic [15:0] v, output bit bad);
    int r;
    logic [3:0] nib;
    r = 0;
    bad = 0;
    for (int i = 3; i >= 0; i--) begin
      nib = v[4*i +: 4];
      if (nib > 4'd9) bad = 1;
      r = r * 10 + int'(nib);
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int m);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd(input bit allow_bad);
    logic [15:0] v;
    int idx;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      idx = $urandom_range(0, 3);
      v[4*idx +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // Calculator behaviour in plain signed integers; acc holds the running value.
  task automatic model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] e_res, output logic e_neg,
                       output logic e_ovf, output logic e_err);
    bit ba, bb;
    int va, vb, r, mag;
    va = bcd_val(a, ba);
    vb = bcd_val(b, bb);
    e_err = ba | bb;
    if (e_err) begin
      e_res = '0;
      e_neg = 1'b0;
      e_ovf = 1'b0;
    end else begin
      r     = (o[1] ? acc : va) + (o[0] ? -vb : vb);
      mag   = (r < 0) ? -r : r;
      e_neg = (r < 0);
      e_ovf = (mag >= 10000);
      if (e_ovf) mag = mag - 10000;
      if (mag == 0) e_neg = 1'b0;
      acc   = e_neg ? -mag : mag;
      e_res = to_bcd(mag);
    end
  endtask

  task automatic clear_model();
    acc = 0;
    prev_res = '0;
    prev_neg = 1'b0;
    prev_ovf = 1'b0;
    prev_err = 1'b0;
  endtask

  // Called at the first falling edge after the accepting edge.
  task automatic wait_result(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                             input bit pulse);
    int n;
    logic [15:0] er;
    logic en, eo, ee;
    model(o, a, b, er, en, eo, ee);
    check("busy_on", busy, 1);
    check("valid_clr", isValid, 0);
    n = 0;
    while (!done && n < 40) begin
      if (n == 10) begin
        check("res_hold", res, prev_res);
        check("neg_hold", isNeg, prev_neg);
        check("ovf_hold", overflow, prev_ovf);
        check("err_hold", error, prev_err);
      end
      if (pulse) start = (n == 2 || n == 9);
      @(negedge clk);
      n++;
    end
    check("latency", n, 19);
    check("res", res, er);
    check("isNeg", isNeg, en);
    check("overflow", overflow, eo);
    check("error", error, ee);
    check("isValid", isValid, 1);
    check("busy_off", busy, 0);
    prev_res = er;
    prev_neg = en;
    prev_ovf = eo;
    prev_err = ee;
    $display("[TB] op=%0d num1=%h num2=%h -> res=%h isNeg=%0d overflow=%0d error=%0d latency=%0d",
             o, a, b, res, isNeg, overflow, error, n);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input bit pulse);
    @(negedge clk);
    op = o; num1 = a; num2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    num1  = 16'($urandom);
    num2  = 16'($urandom);
    wait_result(o, a, b, pulse);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("valid_keep", isValid, 1);
    check("res_keep", res, prev_res);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {busy, done, isValid, isNeg, overflow, error, res}, '0);
  endtask

  task automatic idle_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_idle");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seen_done;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst_init");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    do_op(OP_ADD, 16'h1234, 16'h5678, 0);
    check("tp_add", res, 16'h6912);
    do_op(OP_SUB, 16'h0123, 16'h4567, 0);
    check("tp_sub", {isNeg, res}, {1'b1, 16'h4444});
    do_op(OP_ADD, 16'h9999, 16'h0001, 0);
    check("tp_ovf", {overflow, isNeg, res}, {1'b1, 1'b0, 16'h0000});

    idle_reset();
    do_op(OP_ADD, 16'h0005, 16'h0003, 0);
    check("tp_acc0", res, 16'h0008);
    do_op(OP_ACC_ADD, rand_bcd(0), 16'h0010, 0);
    check("tp_acc1", res, 16'h0018);
    do_op(OP_ACC_SUB, rand_bcd(0), 16'h0020, 0);
    check("tp_acc2", {isNeg, res}, {1'b1, 16'h0002});
    do_op(OP_ACC_ADD, rand_bcd(0), 16'h0002, 0);
    check("tp_acc3", {isNeg, res}, {1'b0, 16'h0000});

    do_op(OP_ADD, 16'h12A4, 16'h0042, 0);
    check("tp_err", {error, res}, {1'b1, 16'h0000});
    do_op(OP_ACC_ADD, rand_bcd(0), 16'h0001, 0);
    check("tp_err_acc", {error, res}, {1'b0, 16'h0001});

    do_op(OP_ADD, 16'h0456, 16'h0321, 1);

    // start held high: each accepted op completes 19 edges after acceptance
    @(negedge clk);
    op = OP_ACC_ADD; num1 = 16'h0000; num2 = 16'h0001; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_result(OP_ACC_ADD, 16'h0000, 16'h0001, 0);
      if (k == 2) start = 1'b0;
      @(negedge clk);
    end
    check("b2b_stop", busy, 0);

    // reset in the middle of an operation
    @(negedge clk);
    op = OP_ACC_ADD; num1 = 16'h0000; num2 = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_midop");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("no_done_after_rst", seen_done, 0);
    check_reset_outputs("rst_quiet");
    do_op(OP_ACC_ADD, rand_bcd(0), 16'h0007, 0);
    check("tp_rst_acc", {isNeg, res}, {1'b0, 16'h0007});

    for (int t = 0; t < 30; t++) begin
      do_op(2'($urandom_range(0, 3)), rand_bcd(1), rand_bcd(1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_alu_seq.md
# bcd_alu_seq

Sequential, parametrised BCD arithmetic unit for the calculator datapath, sitting between the keypad/operand registers and the display driver. It accepts two DIGITS-wide packed-BCD operands, converts them to binary over several cycles, then adds or subtracts. Both operands may come from the inputs, or operand A may be a signed running accumulator. It converts the result back to BCD with a sequential double-dabble and reports sign, overflow and invalid-digit error through a start/done handshake.

## Interface
- DIGITS, 4: BCD digits per operand and result (2..8)
- BIN_W, ceil(log2(10^DIGITS)) (14 for DIGITS=4): internal magnitude width; derived, not overridden
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- op  in  2  00 add A+B, 01 sub A−B, 10 acc+B, 11 acc−B
- num1  in  4*DIGITS  operand A, packed BCD, most significant digit in top nibble
- num2  in  4*DIGITS  operand B, same format
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when results are updated
- isValid  out  1  level; results valid, cleared on the next accepted start
- res  out  4*DIGITS  result magnitude, packed BCD
- isNeg  out  1  result sign
- overflow  out  1  magnitude ≥ 10^DIGITS; res holds magnitude − 10^DIGITS
- error  out  1  a num1/num2 nibble > 9 was seen
- Reset values: every output 0, accumulator 0 and positive, FSM in IDLE.

## Operation
- FSM states: IDLE → CONV → ARITH → DABBLE → IDLE.
- IDLE: when start=1, latch num1, num2 and op, clear isValid, set busy, enter CONV.
- CONV: DIGITS cycles, one digit per cycle, most significant digit first, for both operands in parallel: bin = bin*10 + digit.
  - Any digit > 9 sets a sticky error flag.
  - For op 1x, the num1 conversion result is ignored and A = accumulator (sign + BIN_W+1-bit magnitude).
- ARITH: one cycle, signed-magnitude add/sub on BIN_W+2 bits.
  - Magnitude ≥ 10^DIGITS: subtract 10^DIGITS once and set overflow.
  - A zero result is always positive.
  - With error set: res=0, isNeg=0, overflow=0, error=1, accumulator unchanged.
  - Without error: the accumulator takes the signed, wrapped result.
- DABBLE: BIN_W cycles of shift-and-add-3 via the sub-module.
  - After the last shift: register res, isNeg, overflow, error; pulse done; set isValid; drop busy; return to IDLE.
- start while busy=1 is ignored, with no queueing.
- op and num inputs may change after the accepted start without effect.
- rst_n low mid-operation aborts immediately: all outputs and the accumulator return to 0, with no done pulse.

## Timing
- Start accepted at edge 0 → CONV edges 1..DIGITS → ARITH edge DIGITS+1 → DABBLE edges DIGITS+2..DIGITS+1+BIN_W.
- done and isValid are high after edge DIGITS+1+BIN_W (edge 19 for DIGITS=4).
- busy is high for DIGITS+1+BIN_W cycles.
- A new start may be given in the same cycle done is high; it is accepted at the next edge, giving back-to-back operation.
- error, overflow and isNeg change only when done pulses (error also clears on reset).

## Structure
- Package bcd_pkg holds:
  - op encodings (OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB)
  - FSM state enum
  - constant function computing BIN_W and 10^DIGITS from DIGITS
- Sub-module bin_to_bcd_seq (parameters DIGITS, BIN_W):
  - load/shift-in behaviour, BIN_W-cycle double-dabble with a done strobe
  - reusable by the display path.

## Test plan
- DIGITS=4, 1234 + 5678 (op 00) → res 6912, isNeg 0, overflow 0, done exactly 19 cycles after start.
- 0123 − 4567 (op 01) → res 4444, isNeg 1; then 9999 + 0001 → res 0000, overflow 1, isNeg 0.
- Accumulator chain:
  - reset, then 0005 + 0003 → 0008;
  - op 10, num2=0010 → 0018;
  - op 11, num2=0020 → res 0002, isNeg 1;
  - op 10, num2=0002 → res 0000, isNeg 0.
- num1 = 0x12A4 (op 00) → error 1, res 0; the following op 10 with num2=0001 uses the old accumulator value.
- start re-pulsed at cycles 3 and 10 while busy → ignored, single done; start held high → back-to-back results each 19 cycles.
- rst_n low at cycle 8 of an operation → all outputs 0 asynchronously, no done; after release, op 10 with num2=0007 → 0007.
